// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between fetch, loads, committed stores and IO reads.
// Grants by fixed priority, then steps through 1/2/4 byte accesses into a little-endian word.
module mem_arbiter #(
   parameter int         ADDR_W = 32,
   parameter int         DATA_W = 32,
   parameter logic [1:0] IO_HI  = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_inst,
   input  logic              lsb_req,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [2:0]        lsb_size,
   output logic              lsb_done,
   output logic [DATA_W-1:0] lsb_data,
   input  logic              st_req,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [5:0]        st_size,
   input  logic [DATA_W-1:0] st_data,
   output logic              st_done,
   input  logic              io_req,
   input  logic [ADDR_W-1:0] io_addr,
   output logic              io_done,
   output logic [DATA_W-1:0] io_data,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;
   typedef enum logic [1:0] {OWN_IF, OWN_LSB, OWN_IO, OWN_ST} owner_t;
   localparam int LANES = DATA_W / 8;

   state_t            state_reg, state_next;
   owner_t            owner_reg, owner_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic [2:0]        size_reg, size_next;
   logic [2:0]        step_reg, step_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic [DATA_W-1:0] buf_reg, buf_next, buf_cap;
   logic [ADDR_W-1:0] mem_a_reg, mem_a_next;
   logic [7:0]        mem_dout_reg, mem_dout_next;
   logic              mem_wr_reg, mem_wr_next;
   logic              if_done_reg, if_done_next;
   logic              lsb_done_reg, lsb_done_next;
   logic              st_done_reg, st_done_next;
   logic              io_done_reg, io_done_next;
   logic [DATA_W-1:0] if_inst_reg, if_inst_next;
   logic [DATA_W-1:0] lsb_data_reg, lsb_data_next;
   logic [DATA_W-1:0] io_data_reg, io_data_next;

   function automatic logic [2:0] norm_size(input logic [5:0] sz);
      case (sz)
         6'd1:    return 3'd1;
         6'd2:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // clear suppresses every read grant on its edge; stores are committed and still win
   logic gnt_st, gnt_io, gnt_lsb, gnt_if;
   assign gnt_st  = st_req;
   assign gnt_io  = !clear && !st_req && io_req;
   assign gnt_lsb = !clear && !st_req && !io_req && lsb_req;
   assign gnt_if  = !clear && !st_req && !io_req && !lsb_req && if_req;

   // step_reg counts edges since grant in READ and bytes written in WRITE
   logic [2:0]        rd_step;
   logic              rd_issue, rd_cap, seq_end, wr_stall;
   logic [1:0]        cap_idx;
   logic [ADDR_W-1:0] wr_addr;
   assign rd_step  = step_reg + 3'd1;
   assign rd_issue = rd_step < size_reg;
   assign rd_cap   = rd_step >= 3'd2;
   assign cap_idx  = 2'(rd_step - 3'd2);
   assign seq_end  = step_reg == size_reg;
   assign wr_addr  = base_reg + ADDR_W'(step_reg[1:0]);
   assign wr_stall = (wr_addr[17:16] == IO_HI) && io_buffer_full;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign buf_cap[gi*8 +: 8] = (rd_cap && cap_idx == 2'(gi)) ? mem_din : buf_reg[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         owner_reg    <= OWN_IF;
         base_reg     <= '0;
         size_reg     <= 3'd0;
         step_reg     <= 3'd0;
         wdata_reg    <= '0;
         buf_reg      <= '0;
         mem_a_reg    <= '0;
         mem_dout_reg <= 8'd0;
         mem_wr_reg   <= 1'b0;
         if_done_reg  <= 1'b0;
         lsb_done_reg <= 1'b0;
         st_done_reg  <= 1'b0;
         io_done_reg  <= 1'b0;
         if_inst_reg  <= '0;
         lsb_data_reg <= '0;
         io_data_reg  <= '0;
      end else if (rdy) begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         base_reg     <= base_next;
         size_reg     <= size_next;
         step_reg     <= step_next;
         wdata_reg    <= wdata_next;
         buf_reg      <= buf_next;
         mem_a_reg    <= mem_a_next;
         mem_dout_reg <= mem_dout_next;
         mem_wr_reg   <= mem_wr_next;
         if_done_reg  <= if_done_next;
         lsb_done_reg <= lsb_done_next;
         st_done_reg  <= st_done_next;
         io_done_reg  <= io_done_next;
         if_inst_reg  <= if_inst_next;
         lsb_data_reg <= lsb_data_next;
         io_data_reg  <= io_data_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (gnt_st)
               state_next = WRITE;
            else if (gnt_io || gnt_lsb || gnt_if)
               state_next = READ;
         end
         READ: begin
            if (clear)
               state_next = IDLE;
            else if (seq_end)
               state_next = ACK;
         end
         WRITE: if (seq_end) state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      owner_next    = owner_reg;
      base_next     = base_reg;
      size_next     = size_reg;
      step_next     = step_reg;
      wdata_next    = wdata_reg;
      buf_next      = buf_reg;
      mem_a_next    = mem_a_reg;
      mem_dout_next = mem_dout_reg;
      mem_wr_next   = 1'b0;
      if_done_next  = 1'b0;
      lsb_done_next = 1'b0;
      st_done_next  = 1'b0;
      io_done_next  = 1'b0;
      if_inst_next  = if_inst_reg;
      lsb_data_next = lsb_data_reg;
      io_data_next  = io_data_reg;
      case (state_reg)
         IDLE: begin
            step_next = 3'd0;
            buf_next  = '0;
            if (gnt_st) begin
               owner_next = OWN_ST;
               base_next  = st_addr;
               size_next  = norm_size(st_size);
               wdata_next = st_data;
            end else if (gnt_io) begin
               owner_next = OWN_IO;
               base_next  = io_addr;
               size_next  = 3'd4;
               mem_a_next = io_addr;
            end else if (gnt_lsb) begin
               owner_next = OWN_LSB;
               base_next  = lsb_addr;
               size_next  = norm_size({3'b000, lsb_size});
               mem_a_next = lsb_addr;
            end else if (gnt_if) begin
               owner_next = OWN_IF;
               base_next  = if_addr;
               size_next  = 3'd4;
               mem_a_next = if_addr;
            end
         end
         READ: begin
            if (!clear) begin
               step_next = rd_step;
               buf_next  = buf_cap;
               if (rd_issue)
                  mem_a_next = base_reg + ADDR_W'(rd_step[1:0]);
               if (seq_end) begin
                  case (owner_reg)
                     OWN_IF:  begin if_done_next  = 1'b1; if_inst_next  = buf_cap; end
                     OWN_LSB: begin lsb_done_next = 1'b1; lsb_data_next = buf_cap; end
                     OWN_IO:  begin io_done_next  = 1'b1; io_data_next  = buf_cap; end
                     default: ;
                  endcase
               end
            end
         end
         WRITE: begin
            if (seq_end) begin
               st_done_next = 1'b1;
            end else if (!wr_stall) begin
               mem_a_next    = wr_addr;
               mem_dout_next = wdata_reg[{step_reg[1:0], 3'b000} +: 8];
               mem_wr_next   = 1'b1;
               step_next     = step_reg + 3'd1;
            end
         end
         default: ;
      endcase
   end

   assign if_done  = if_done_reg;
   assign if_inst  = if_inst_reg;
   assign lsb_done = lsb_done_reg;
   assign lsb_data = lsb_data_reg;
   assign st_done  = st_done_reg;
   assign io_done  = io_done_reg;
   assign io_data  = io_data_reg;
   assign mem_a    = mem_a_reg;
   assign mem_dout = mem_dout_reg;
   assign mem_wr   = mem_wr_reg;
endmodule
